// File: rtl/coriolis_ker1_instream_join_pkg.sv
// coriolis_ker1_instream_join_pkg: shared widths, depth and run-control state type
package coriolis_ker1_instream_join_pkg;
    localparam int DEF_STREAMW = 34;
    localparam int DEF_AW      = 2;
    localparam int DEF_CNTW    = 32;
    localparam int DEPTH       = 1 << DEF_AW;
    typedef enum logic {IDLE, RUN} run_state_t;
endpackage

// File: rtl/coriolis_stream_fifo.sv
// coriolis_stream_fifo: first-word-fall-through sync FIFO, depth 2**AW
// Ports: push/din write side; pop/head read side (head valid while !empty); full/empty status.
module coriolis_stream_fifo #(
    parameter int W  = 34,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    logic [AW:0]  wr, rd;
    logic [W-1:0] mem [2**AW];
    // the extra pointer bit separates full (MSBs differ) from empty (pointers equal)
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign empty = wr == rd;
    assign head  = mem[rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push && !full) begin
                mem[wr[AW-1:0]] <= din;
                wr <= wr + 1'b1;
            end
            if (pop && !empty) rd <= rd + 1'b1;
        end
    end
endmodule

// File: rtl/coriolis_ker1_instream_join.sv
// coriolis_ker1_instream_join: buffers x/un producer streams and delivers them as lock-stepped pairs with a run counter
// Ports: start/nelem arm a run; x_in*/un_in* producer handshakes; x_s0/un_s0/ivalid_*/iready kernel side; count/done run status.
module coriolis_ker1_instream_join
    import coriolis_ker1_instream_join_pkg::*;
#(
    parameter int STREAMW = DEF_STREAMW,
    parameter int AW      = DEF_AW,
    parameter int CNTW    = DEF_CNTW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTW-1:0]    nelem,
    input  logic [STREAMW-1:0] x_in,
    input  logic               x_in_valid,
    output logic               x_in_ready,
    input  logic [STREAMW-1:0] un_in,
    input  logic               un_in_valid,
    output logic               un_in_ready,
    output logic [STREAMW-1:0] x_s0,
    output logic [STREAMW-1:0] un_s0,
    output logic               ivalid_x_s0,
    output logic               ivalid_un_s0,
    input  logic               iready,
    output logic [CNTW-1:0]    count,
    output logic               done
);
    logic               full_x, empty_x, full_u, empty_u, pv, fire;
    logic [STREAMW-1:0] head_x, head_u;
    logic [CNTW-1:0]    nelem_r;
    run_state_t         state, state_d;

    coriolis_stream_fifo #(.W(STREAMW), .AW(AW)) u_fifo_x (
        .clk(clk), .rst(rst), .push(x_in_valid), .din(x_in), .pop(fire),
        .head(head_x), .full(full_x), .empty(empty_x)
    );
    coriolis_stream_fifo #(.W(STREAMW), .AW(AW)) u_fifo_un (
        .clk(clk), .rst(rst), .push(un_in_valid), .din(un_in), .pop(fire),
        .head(head_u), .full(full_u), .empty(empty_u)
    );

    always_comb begin
        pv      = (state == RUN) && !done && !empty_x && !empty_u;
        fire    = pv && iready;
        state_d = start ? RUN : done ? IDLE : state;
    end

    assign x_in_ready   = !full_x;
    assign un_in_ready  = !full_u;
    assign ivalid_x_s0  = pv;
    assign ivalid_un_s0 = pv;
    // gate heads so the kernel sees a steady zero whenever no pair is offered
    assign x_s0         = pv ? head_x : '0;
    assign un_s0        = pv ? head_u : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            nelem_r <= '0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_d;
            // start outranks a coincident fire: the pair still pops but is not counted
            if (start) begin
                nelem_r <= nelem;
                count   <= '0;
                done    <= nelem == '0;
            end else if (fire) begin
                count <= count + 1'b1;
                if (count == nelem_r - 1'b1) done <= 1'b1;
            end
        end
    end
endmodule
